// File: rtl/reg_file_opstage_pkg.sv
// Shared widths and ALU control codes for the operand-fetch stage and the ALU.
// Keeping them here lets issue logic and the ALU agree on one encoding.
package reg_file_opstage_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 5;
    localparam int DEF_CW = 3;

    localparam logic [DEF_CW-1:0] ALU_AND = 3'b000;
    localparam logic [DEF_CW-1:0] ALU_OR  = 3'b001;
    localparam logic [DEF_CW-1:0] ALU_ADD = 3'b010;
    localparam logic [DEF_CW-1:0] ALU_SUB = 3'b110;
    localparam logic [DEF_CW-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/reg_file_opstage_regfile_2r1w.sv
// NREG x DW register file: two async read ports, one async debug read port,
// one synchronous write port. Register 0 always reads as zero.
module regfile_2r1w
    import reg_file_opstage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_a_addr,
    output logic [DW-1:0] rd_a_data,
    input  logic [AW-1:0] rd_b_addr,
    output logic [DW-1:0] rd_b_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);
    localparam int NREG = 2 ** AW;

    logic [DW-1:0] regs_reg [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    // Address 0 is masked on read so the stored entry never matters.
    assign rd_a_data = (rd_a_addr == '0) ? '0 : regs_reg[rd_a_addr];
    assign rd_b_data = (rd_b_addr == '0) ? '0 : regs_reg[rd_b_addr];
    assign dbg_data  = (dbg_addr  == '0) ? '0 : regs_reg[dbg_addr];

endmodule

// File: rtl/reg_file_opstage.sv
// Operand-fetch stage: reads two sources with same-cycle writeback forwarding
// and holds them in a one-entry valid/ready output register toward the ALU.
module reg_file_opstage
    import reg_file_opstage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_valid,
    output logic          iss_ready,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic [CW-1:0] ctr_in,
    input  logic [AW-1:0] dest_in,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] op_A,
    output logic [DW-1:0] op_B,
    output logic [CW-1:0] op_ctr,
    output logic [AW-1:0] op_dest,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic          fire;

    logic          op_valid_reg;
    logic [DW-1:0] op_a_reg;
    logic [DW-1:0] op_b_reg;
    logic [CW-1:0] op_ctr_reg;
    logic [AW-1:0] op_dest_reg;

    regfile_2r1w #(.DW(DW), .AW(AW)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data),
        .rd_a_addr (rs_addr),
        .rd_a_data (rs_data),
        .rd_b_addr (rt_addr),
        .rd_b_data (rt_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // A writeback landing on the same edge as the capture must be seen by the op.
    assign fwd_a = (rs_addr != '0 && wb_en && wb_addr == rs_addr) ? wb_data : rs_data;
    assign fwd_b = (rt_addr != '0 && wb_en && wb_addr == rt_addr) ? wb_data : rt_data;

    assign iss_ready = !op_valid_reg || op_ready;
    assign fire      = iss_valid && iss_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid_reg <= 1'b0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_ctr_reg   <= '0;
            op_dest_reg  <= '0;
        end else if (fire) begin
            op_valid_reg <= 1'b1;
            op_a_reg     <= fwd_a;
            op_b_reg     <= fwd_b;
            op_ctr_reg   <= ctr_in;
            op_dest_reg  <= dest_in;
        end else if (op_valid_reg && op_ready) begin
            op_valid_reg <= 1'b0;
        end
    end

    assign op_valid = op_valid_reg;
    assign op_A     = op_a_reg;
    assign op_B     = op_b_reg;
    assign op_ctr   = op_ctr_reg;
    assign op_dest  = op_dest_reg;

endmodule
